rr_arbiter_n: RTL
=================

Name: rr_arbiter_n

Overview:
N-way round-robin arbiter with registered, one-hot grant and tenure locking. The grant is held until the owner signals release or drops its request. Successor to the 2-way frame-buffer port arbiter. Multiplexes N frame-buffer clients (video read, DMA write, CPU, refresh) onto the single memory command port. Grant is registered, so it drives the downstream mux select directly.

Parameters:
N, 4, number of requesters; legal range 2..16
MAX_HOLD, 16, maximum tenure in cycles; used only with RR_ARB_MAX_HOLD_EN; legal range 2..255
IDXW, $clog2(N), local parameter; width of grant_idx

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
req  input  N  request vector; bit i = requester i
release  input  1  owner ends tenure; sampled only while grant_valid=1
grant  output  N  registered one-hot grant; all zero when idle
grant_valid  output  1  registered; equals |grant
grant_idx  output  IDXW  registered index of the current owner; holds the last owner while idle
preempt  output  1  registered one-cycle pulse when a tenure was forcibly ended (see Optional Feature)

Behaviour:
- Reset, sampled at the edge:
  - grant=0, grant_valid=0, grant_idx=0, preempt=0.
  - Internal last_winner=N-1, so requester 0 has top priority first.
  - Hold counter=0 and state=IDLE.
  - Reset overrides everything, including mid-tenure; no release is needed.
- States: IDLE (no owner) and LOCKED (one owner, grant_valid=1).
- Winner search:
  - Scan req from index last_winner+1 upward, wrapping modulo N.
  - The first set bit wins, so last_winner always has the lowest priority.
  - Pure combinational search; the result is registered.
- IDLE:
  - req==0: stay IDLE, outputs zero.
  - Otherwise: at the edge, grant=onehot(winner), grant_idx=winner, last_winner=winner, state=LOCKED.
  - Latency is 1 cycle: req seen before edge k produces grant valid after edge k.
- LOCKED, owner o:
  - The tenure ends at an edge where release=1 or req[o]=0. That edge performs a new search on the current req with last_winner=o.
  - If a winner is found: grant moves directly to it with no bubble cycle. The owner is re-granted only if it is the sole requester.
  - If no winner is found: grant=0, state=IDLE.
  - Otherwise grant, grant_idx and last_winner hold unchanged, whatever the other requests do.
- Ignored inputs:
  - release while IDLE is ignored.
  - release and a dropped req[o] in the same cycle count as a single end of tenure.
- Simultaneous events:
  - New requests arriving during a tenure are only considered at the end of that tenure.
  - A request that is asserted and then dropped while another client owns the grant is lost. Requesters hold req until granted.
- Invariant: grant is one-hot or zero at every cycle after reset; grant_idx matches the set bit of grant whenever grant_valid=1.

Optional Feature:
- Macro: RR_ARB_MAX_HOLD_EN.
- Enabled:
  - An 8-bit hold counter clears on every new grant and increments each LOCKED cycle.
  - When the owner has held for MAX_HOLD cycles with no release, that edge force-ends the tenure exactly as a release would.
  - preempt=1 for the single cycle after that edge, then returns to 0.
  - A normal release on the same edge takes precedence and gives preempt=0.
- Disabled:
  - No counter is built; tenure is unbounded.
  - preempt is tied to 0 and MAX_HOLD is ignored.
  - The port list is unchanged.

Test Plan:
1. Reset: assert reset 2 cycles with req=4'b1111 -> grant=0, grant_valid=0, grant_idx=0, preempt=0. The first grant after deassertion is 4'b0001.
2. Rotation: N=4, req=4'b1111 steady, release=1 every cycle -> grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with no idle bubble.
3. Lock: req=4'b0011, owner 0 granted, release=0 for 5 cycles -> grant stays 0001. Pulse release -> next cycle grant=0010, grant_idx=1.
4. Drop and idle: owner 2 alone (req=4'b0100), drop req to 0 -> next cycle grant=0, grant_valid=0, grant_idx stays 2. Then req=4'b1100 -> grant=1000, since index 3 follows last winner 2.
5. Reset mid-tenure: owner 1 locked, assert reset one cycle while req=4'b1111 -> grant=0 that cycle, then grant=0001.
6. With RR_ARB_MAX_HOLD_EN, MAX_HOLD=4: req=4'b0011 steady, no release -> grant=0001 for exactly 4 cycles, then grant=0010 with preempt=1 for that first cycle only. Without the macro, grant stays 0001 indefinitely and preempt=0.

Source files
------------

// File: rtl/rr_arbiter_n_if.sv
// -----------------------------------------------------------------------------
// rr_arbiter_n_if
// Request/grant bundle between the frame-buffer clients and rr_arbiter_n.
//
// Parameters:
//   N    number of requesters (2..16)
//
// Signals:
//   req             N     request vector, bit i = requester i
//   release_tenure  1     current owner ends its tenure (named so because
//                         "release" is a reserved word in SystemVerilog)
//   grant           N     registered one-hot grant, zero when idle
//   grant_valid     1     registered, equals |grant
//   grant_idx       IDXW  registered index of the current/last owner
//   preempt         1     registered one-cycle pulse on a forced tenure end
//
// Modports:
//   master  arbiter side: drives grant/grant_valid/grant_idx/preempt
//   slave   client side:  drives req/release_tenure
// -----------------------------------------------------------------------------
interface rr_arbiter_n_if #(
   parameter int N = 4
);
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]    req;
   logic            release_tenure;
   logic [N-1:0]    grant;
   logic            grant_valid;
   logic [IDXW-1:0] grant_idx;
   logic            preempt;

   modport master (
      input  req,
      input  release_tenure,
      output grant,
      output grant_valid,
      output grant_idx,
      output preempt
   );

   modport slave (
      output req,
      output release_tenure,
      input  grant,
      input  grant_valid,
      input  grant_idx,
      input  preempt
   );
endinterface

// File: rtl/rr_arbiter_n.sv
// -----------------------------------------------------------------------------
// rr_arbiter_n
// N-way round-robin arbiter with a registered one-hot grant and tenure
// locking. The owner keeps the grant until it releases or drops its request;
// the grant then moves straight to the next requester after the owner in
// round-robin order, with no idle bubble.
//
// Parameters:
//   N         number of requesters (2..16)
//   MAX_HOLD  maximum tenure in cycles (2..255), only with RR_ARB_MAX_HOLD_EN
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  synchronous active-high reset
//   bus    rr_arbiter_n_if.master (req, release_tenure in;
//          grant, grant_valid, grant_idx, preempt out)
//
// Optional feature (macro RR_ARB_MAX_HOLD_EN):
//   An 8-bit hold counter force-ends a tenure after MAX_HOLD cycles and
//   pulses preempt for one cycle. Without the macro no counter is built,
//   tenure is unbounded and preempt stays 0.
// -----------------------------------------------------------------------------
module rr_arbiter_n #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic           clk,
   input  logic           reset,
   rr_arbiter_n_if.master bus
);
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;

   if ((N < 2) || (N > 16)) begin : g_bad_n
      $error("rr_arbiter_n: N out of range 2..16");
   end
   if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_hold
      $error("rr_arbiter_n: MAX_HOLD out of range 2..255");
   end

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // Round-robin search: scanning offsets from N down to 1 means the
   // smallest offset after last (highest priority) is written last and wins.
   // Returns {found, index}.
   function automatic logic [IDXW:0] find_winner(input logic [N-1:0]    r,
                                                  input logic [IDXW-1:0] last);
      logic [IDXW:0]   res;
      logic [IDXW-1:0] p;
      int              pos;
      res = {(IDXW+1){1'b0}};
      for (int off = N; off >= 1; off--) begin
         pos = (int'(last) + off) % N;
         p   = pos[IDXW-1:0];
         res = r[p] ? {1'b1, p} : res;
      end
      return res;
   endfunction

   state_t          state_r,       state_nxt_s;
   logic [N-1:0]    grant_r,       grant_nxt_s;
   logic            grant_valid_r, grant_valid_nxt_s;
   logic [IDXW-1:0] grant_idx_r,   grant_idx_nxt_s;
   logic [IDXW-1:0] last_r,        last_nxt_s;
   logic            preempt_r,     preempt_nxt_s;

   logic [IDXW:0]   search_s;
   logic            found_s;
   logic [IDXW-1:0] win_idx_s;
   logic [N-1:0]    win_onehot_s;
   logic            normal_end_s;
   logic            expire_s;
   logic            end_s;

   // last_r always equals the owner while LOCKED, so one search serves both states.
   assign search_s     = find_winner(bus.req, last_r);
   assign found_s      = search_s[IDXW];
   assign win_idx_s    = search_s[IDXW-1:0];
   assign win_onehot_s = {{(N-1){1'b0}}, 1'b1} << win_idx_s;
   assign normal_end_s = bus.release_tenure | ~bus.req[grant_idx_r];
   assign end_s        = normal_end_s | expire_s;

`ifdef RR_ARB_MAX_HOLD_EN
   logic [7:0] hold_r;

   // Hold counter: cleared on every new grant, counts cycles of the current tenure.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_r <= 8'd0;
      end else if ((state_r == LOCKED) && !end_s) begin
         hold_r <= hold_r + 8'd1;
      end else begin
         hold_r <= 8'd0;
      end
   end

   // hold_r == MAX_HOLD-1 means this edge closes the MAX_HOLD-th granted cycle.
   assign expire_s = (state_r == LOCKED) && (hold_r == 8'(MAX_HOLD - 1));
`else
   assign expire_s = 1'b0;
`endif

   // Next-state and next-output logic for the IDLE/LOCKED machine.
   always_comb begin
      state_nxt_s       = state_r;
      grant_nxt_s       = grant_r;
      grant_valid_nxt_s = grant_valid_r;
      grant_idx_nxt_s   = grant_idx_r;
      last_nxt_s        = last_r;
      preempt_nxt_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               state_nxt_s       = LOCKED;
               grant_nxt_s       = win_onehot_s;
               grant_valid_nxt_s = 1'b1;
               grant_idx_nxt_s   = win_idx_s;
               last_nxt_s        = win_idx_s;
            end else begin
               grant_nxt_s       = {N{1'b0}};
               grant_valid_nxt_s = 1'b0;
            end
         end
         LOCKED: begin
            if (end_s) begin
               // A normal end on the same edge wins over the forced one.
               preempt_nxt_s = expire_s & ~normal_end_s;
               if (found_s) begin
                  grant_nxt_s       = win_onehot_s;
                  grant_valid_nxt_s = 1'b1;
                  grant_idx_nxt_s   = win_idx_s;
                  last_nxt_s        = win_idx_s;
               end else begin
                  state_nxt_s       = IDLE;
                  grant_nxt_s       = {N{1'b0}};
                  grant_valid_nxt_s = 1'b0;
               end
            end else begin
               state_nxt_s = LOCKED;
            end
         end
         default: begin
            state_nxt_s       = IDLE;
            grant_nxt_s       = {N{1'b0}};
            grant_valid_nxt_s = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset leaves requester 0 with top priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         grant_r       <= {N{1'b0}};
         grant_valid_r <= 1'b0;
         grant_idx_r   <= {IDXW{1'b0}};
         last_r        <= IDXW'(N - 1);
         preempt_r     <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         grant_r       <= grant_nxt_s;
         grant_valid_r <= grant_valid_nxt_s;
         grant_idx_r   <= grant_idx_nxt_s;
         last_r        <= last_nxt_s;
         preempt_r     <= preempt_nxt_s;
      end
   end

   assign bus.grant       = grant_r;
   assign bus.grant_valid = grant_valid_r;
   assign bus.grant_idx   = grant_idx_r;
   assign bus.preempt     = preempt_r;
endmodule
